// File: rtl/fetch_queue_if.sv
// Shared RISC-V types plus the fetch->decode queue interface.
// Latency: n/a (type and wire bundle only).
// Backpressure: carries in_ready toward fetch and out_ready from decode.
//
// Signals: flush, in_valid/in_ready/in_pc/in_instr/in_pc_plus4/in_pred_taken/
// in_pred_target from fetch; out_valid/out_ready/out_entry/out_pred_taken/
// out_pred_target toward decode; count/full/empty status.
package riscv_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc_plus4;
        logic            valid_if_id;
    } if_id_reg_t;
endpackage

interface fetch_queue_if #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 4
);
    import riscv_pkg::*;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_instr;
    logic [XLEN-1:0]  in_pc_plus4;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic             out_valid;
    logic             out_ready;
    if_id_reg_t       out_entry;
    logic             out_pred_taken;
    logic [XLEN-1:0]  out_pred_target;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    // Environment side: fetch, decode and the EX redirect.
    modport master (
        output flush, in_valid, in_pc, in_instr, in_pc_plus4, in_pred_taken,
               in_pred_target, out_ready,
        input  in_ready, out_valid, out_entry, out_pred_taken, out_pred_target,
               count, full, empty
    );

    // Queue side.
    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_pc_plus4, in_pred_taken,
               in_pred_target, out_ready,
        output in_ready, out_valid, out_entry, out_pred_taken, out_pred_target,
               count, full, empty
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch->decode instruction queue: DEPTH-entry circular buffer, flushable.
// Latency: a pushed bundle is visible at the head one cycle later (no bypass).
// Backpressure: in_ready = ~full from registered state only; no out_ready->in_ready path.
//
// Ports: clk (rising edge), reset (async active-low), fq (fetch_queue_if.slave)
// carrying the fetch push handshake, decode pop handshake, flush and status.
module fetch_queue #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         reset,
    fetch_queue_if.slave fq
);
    import riscv_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  r_pc       [DEPTH];
    logic [XLEN-1:0]  r_instr    [DEPTH];
    logic [XLEN-1:0]  r_pc_plus4 [DEPTH];
    logic             r_ptaken   [DEPTH];
    logic [XLEN-1:0]  r_ptarget  [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_ptr_diff;
    if_id_reg_t       w_entry;
    logic             w_pred_taken;
    logic [XLEN-1:0]  w_pred_target;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    // A full queue refuses a push even when the head pops this same cycle.
    assign w_push     = fq.in_valid & ~w_full & ~fq.flush;
    assign w_pop      = ~w_empty & fq.out_ready & ~fq.flush;
    assign w_ptr_diff = r_wr_ptr - r_rd_ptr;

    // Pointers and occupancy. Power-of-two DEPTH lets the pointers wrap for free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (fq.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: the head is gated whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]       <= fq.in_pc;
            r_instr[r_wr_ptr]    <= fq.in_instr;
            r_pc_plus4[r_wr_ptr] <= fq.in_pc_plus4;
            r_ptaken[r_wr_ptr]   <= fq.in_pred_taken;
            r_ptarget[r_wr_ptr]  <= fq.in_pred_target;
        end
    end

    // Head read-out, forced to zero while empty (which also covers reset).
    always_comb begin
        w_entry       = '0;
        w_pred_taken  = 1'b0;
        w_pred_target = '0;
        if (!w_empty) begin
            w_entry.pc          = r_pc[r_rd_ptr];
            w_entry.instruction = r_instr[r_rd_ptr];
            w_entry.pc_plus4    = r_pc_plus4[r_rd_ptr];
            w_entry.valid_if_id = 1'b1;
            w_pred_taken        = r_ptaken[r_rd_ptr];
            w_pred_target       = r_ptarget[r_rd_ptr];
        end
    end

    assign fq.in_ready        = ~w_full;
    assign fq.out_valid       = ~w_empty;
    assign fq.out_entry       = w_entry;
    assign fq.out_pred_taken  = w_pred_taken;
    assign fq.out_pred_target = w_pred_target;
    assign fq.count           = r_count;
    assign fq.full            = w_full;
    assign fq.empty           = w_empty;

    a_count_max: assert property (@(posedge clk) disable iff (!reset)
        r_count <= CNT_W'(DEPTH));
    a_full_empty: assert property (@(posedge clk) disable iff (!reset)
        !(w_full && w_empty));
    // When full the pointers coincide, so the difference reads 0, not DEPTH.
    a_count_ptr: assert property (@(posedge clk) disable iff (!reset)
        w_full || (r_count == CNT_W'(w_ptr_diff)));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) fq ();

    fetch_queue #(.XLEN(32), .DEPTH(4)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .fq    (fq.slave)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction word is derived from the pc so ordering errors show in both fields.
    task automatic drive(input logic vld, input logic [31:0] pc,
                         input logic ptaken, input logic [31:0] ptgt);
        fq.in_valid       = vld;
        fq.in_pc          = pc;
        fq.in_instr       = 32'h0000_0013 + (pc << 8);
        fq.in_pc_plus4    = pc + 32'd4;
        fq.in_pred_taken  = ptaken;
        fq.in_pred_target = ptgt;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, 128'(fq.count), 128'd0);
        chk({tag, "_empty"}, 128'(fq.empty), 128'd1);
        chk({tag, "_full"}, 128'(fq.full), 128'd0);
        chk({tag, "_in_ready"}, 128'(fq.in_ready), 128'd1);
        chk({tag, "_out_valid"}, 128'(fq.out_valid), 128'd0);
        chk({tag, "_entry"}, 128'(fq.out_entry), 128'd0);
        chk({tag, "_ptaken"}, 128'(fq.out_pred_taken), 128'd0);
        chk({tag, "_ptgt"}, 128'(fq.out_pred_target), 128'd0);
    endtask

    logic [31:0] exp_pc  [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    int          exp_cnt [5] = '{4, 3, 3, 2, 1};
    logic        exp_rdy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        rst_n        = 1'b0;
        fq.flush     = 1'b0;
        fq.out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #12;
        chk_idle("reset");

        // 1: single push, visible the following cycle
        rst_n = 1'b1;
        drive(1'b1, 32'h0, 1'b0, 32'h0);
        chk("t1_no_bypass", 128'(fq.out_valid), 128'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t1_out_valid", 128'(fq.out_valid), 128'd1);
        chk("t1_valid_if_id", 128'(fq.out_entry.valid_if_id), 128'd1);
        chk("t1_pc", 128'(fq.out_entry.pc), 128'h0);
        chk("t1_instr", 128'(fq.out_entry.instruction), 128'h13);
        chk("t1_pc4", 128'(fq.out_entry.pc_plus4), 128'h4);
        chk("t1_count", 128'(fq.count), 128'd1);
        fq.flush = 1'b1;
        tick();
        fq.flush = 1'b0;
        chk_idle("t1_flush");

        // 2: fill to full, fifth bundle held until a slot frees up
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 32'h10, 1'b0, 32'h0);
        chk("t2_full", 128'(fq.full), 128'd1);
        chk("t2_in_ready", 128'(fq.in_ready), 128'd0);
        chk("t2_count", 128'(fq.count), 128'd4);
        tick();
        chk("t2_refused", 128'(fq.count), 128'd4);
        fq.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_pc%0d", i), 128'(fq.out_entry.pc), 128'(exp_pc[i]));
            chk($sformatf("t2_cnt%0d", i), 128'(fq.count), 128'(exp_cnt[i]));
            chk($sformatf("t2_rdy%0d", i), 128'(fq.in_ready), 128'(exp_rdy[i]));
            tick();
            if (i == 1) drive(1'b0, 32'h0, 1'b0, 32'h0);
        end
        chk("t2_drain_instr_ok", 128'(fq.out_valid), 128'd0);
        chk("t2_drain_empty", 128'(fq.empty), 128'd1);

        // 3: streaming with both sides ready, crossing the pointer wrap
        drive(1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * (i + 1)), 1'b0, 32'h0);
            chk($sformatf("t3_pc%0d", i), 128'(fq.out_entry.pc), 128'(32'h100 + 32'(4 * i)));
            chk($sformatf("t3_instr%0d", i), 128'(fq.out_entry.instruction),
                128'(32'h13 + ((32'h100 + 32'(4 * i)) << 8)));
            chk($sformatf("t3_cnt%0d", i), 128'(fq.count), 128'd1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t3_last_pc", 128'(fq.out_entry.pc), 128'h128);
        tick();
        chk("t3_empty", 128'(fq.empty), 128'd1);
        fq.out_ready = 1'b0;

        // 4: flush beats a same-cycle push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        chk("t4_count3", 128'(fq.count), 128'd3);
        drive(1'b1, 32'h200, 1'b0, 32'h0);
        fq.flush     = 1'b1;
        fq.out_ready = 1'b1;
        tick();
        fq.flush     = 1'b0;
        fq.out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk_idle("t4_flush");
        fq.flush = 1'b1;
        tick();
        fq.flush = 1'b0;
        chk("t4_flush_empty", 128'(fq.empty), 128'd1);
        drive(1'b1, 32'h210, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t4_head_after_flush", 128'(fq.out_entry.pc), 128'h210);
        chk("t4_count_after_flush", 128'(fq.count), 128'd1);
        fq.out_ready = 1'b1;
        tick();
        fq.out_ready = 1'b0;

        // 5: prediction sideband follows the entry and clears when empty
        drive(1'b1, 32'h500, 1'b1, 32'h0000_0400);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t5_ptaken", 128'(fq.out_pred_taken), 128'd1);
        chk("t5_ptgt", 128'(fq.out_pred_target), 128'h400);
        chk("t5_pc", 128'(fq.out_entry.pc), 128'h500);
        fq.out_ready = 1'b1;
        tick();
        fq.out_ready = 1'b0;
        chk_idle("t5_popped");

        // 6: asynchronous reset mid-operation
        drive(1'b1, 32'h600, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h604, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6_count2", 128'(fq.count), 128'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("t6_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6_head", 128'(fq.out_entry.pc), 128'h80);
        chk("t6_count1", 128'(fq.count), 128'd1);
        fq.out_ready = 1'b1;
        tick();
        fq.out_ready = 1'b0;
        chk("t6_alone", 128'(fq.empty), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Buffers fetched instruction bundles (pc, instruction, pc_plus4, prediction info) so that a decode stall does not immediately stall fetch.
- Flushed on branch redirect from EX.
- Outputs the standard IF/ID packed record plus prediction sideband for later misprediction checking.

Parameters:
- XLEN, 32, data/address width (from riscv_pkg).
- DEPTH, 4, number of queue entries; must be a power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter; derived, not overridden.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  branch redirect from EX; discards all entries.
- in_valid  input  1  fetch presents a valid bundle.
- in_ready  output  1  queue can accept a bundle this cycle.
- in_pc  input  XLEN  PC of the fetched instruction.
- in_instr  input  XLEN  instruction word.
- in_pc_plus4  input  XLEN  in_pc + 4.
- in_pred_taken  input  1  branch predictor taken prediction.
- in_pred_target  input  XLEN  predicted target.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode accepts the head entry.
- out_entry  output  $bits(if_id_reg_t)  head entry as if_id_reg_t; valid_if_id mirrors out_valid.
- out_pred_taken  output  1  head entry prediction.
- out_pred_target  output  XLEN  head entry predicted target.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage: circular buffer of DEPTH entries, each holding pc, instr, pc_plus4, pred_taken and pred_target.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a separate count register of CNT_W bits.
- Push: push = in_valid & in_ready & ~flush. Writes entry[wr_ptr] and advances wr_ptr by 1.
- Pop: pop = out_valid & out_ready & ~flush. Advances rd_ptr by 1.
- Handshake inputs: in_ready = ~full, a registered-state function only. There is no combinational path from out_ready to in_ready.
- Full with simultaneous pop: a push is refused while full even if a pop occurs in the same cycle.
- Read latency: out_valid = ~empty. out_entry and out_pred_* are driven combinationally from entry[rd_ptr]. A pushed bundle is visible on the outputs the cycle after it is pushed; there is no same-cycle bypass.
- Output gating: when empty, out_entry.pc, .instruction and .pc_plus4 drive 0, valid_if_id = 0, out_pred_taken = 0 and out_pred_target = 0.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop, which is only possible when 0 < count < DEPTH.
- Pointer wrap: wr_ptr DEPTH-1 -> 0 and rd_ptr DEPTH-1 -> 0. FIFO order is preserved across the wrap.
- Flush (synchronous, highest priority):
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0, full = 0, empty = 1.
  - Any same-cycle push or pop is ignored.
  - Entry storage contents need not be cleared.
- Flush while empty: no effect beyond holding pointers at 0.
- Reset (asynchronous, active-low):
  - While reset = 0: rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, in_ready = 1, out_valid = 0, all out_* data = 0.
  - Takes effect immediately, including mid-operation with queued entries.
  - Deassertion is synchronous to clk at the integration level; the first push is accepted on the first rising edge after release.
- Stall interaction: the fetch stage holds its PC when in_ready = 0. The queue never drops or duplicates an accepted bundle.
- Protocol violations: in_valid without in_ready is legal and the bundle is simply not taken. out_ready while empty is a no-op.
- Assertions (simulation only):
  - count <= DEPTH.
  - full and empty never both asserted.
  - count == (wr_ptr - rd_ptr) mod DEPTH, except when full.

Test Plan:
1. Reset, then push pc 0x0000_0000 instr 0x0000_0013 with out_ready = 0. Next cycle: out_valid = 1, out_entry.pc = 0x0, instruction = 0x13, pc_plus4 = 0x4, count = 1.
2. With out_ready = 0, push 5 consecutive bundles (pc 0x0, 0x4, 0x8, 0xC, 0x10). The first 4 are accepted, then full = 1 and in_ready = 0. The 5th is held by fetch. Raise out_ready: pcs 0x0, 0x4, 0x8, 0xC emerge in order, then 0x10 after it is accepted.
3. Continuous push and pop with both sides ready for 10 cycles (pc 0x100 upward): count stays at 1, pointers wrap past DEPTH-1, and the output pc sequence is 0x100, 0x104, ... in order.
4. With 3 entries queued, assert flush together with in_valid (pc 0x200) and out_ready. Next cycle: count = 0, empty = 1, out_valid = 0, and pc 0x200 is not stored.
5. Push with in_pred_taken = 1 and in_pred_target = 0x0000_0400. The head shows out_pred_taken = 1 and out_pred_target = 0x400. After the pop, the outputs are zero and empty = 1.
6. With 2 entries queued, drive reset low between clock edges. Outputs immediately show count = 0, out_valid = 0, in_ready = 1. After reset is released, a push of pc 0x80 appears alone at the head.
